// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 encodings shared by the write-burst master and its peers.
//   BURST_*  : awburst/arburst encodings
//   RESP_*   : bresp/rresp encodings
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/m_axi_wr_burst.sv
// m_axi_wr_burst: AXI4 write-burst master. Accepts one {addr,len,burst}
// command plus a local beat stream and issues it as a single AW/W/B
// transaction; one transaction in flight at a time.
//   cmd_*      : command handshake (cmd_ready registered, high only in IDLE)
//   wr_*       : local beat stream, passed straight through to W channel
//   done       : 1-cycle completion pulse, done_resp valid with it
//   m_axi_aw*  : address channel, fields latched at command accept
//   m_axi_w*   : data channel, only driven after the AW handshake
//   m_axi_b*   : response channel, bready only while waiting for B
module m_axi_wr_burst
    import axi_pkg::*;
#(
    parameter int                     ID_WIDTH   = 1,
    parameter int                     ADDR_WIDTH = 32,
    parameter int                     DATA_WIDTH = 32,
    parameter logic [ID_WIDTH-1:0]    AXI_ID     = '0
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic                      cmd_incr,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    output logic                      done,
    output logic [1:0]                done_resp,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
    // Mask of the sub-beat address bits, forced to zero on the bus.
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK =
        ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

    typedef enum logic [1:0] {IDLE, AW, W_DATA, W_RESP} state_t;

    state_t                  state, state_next;
    logic [7:0]              cnt;
    logic [7:0]              awlen_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic                    incr_q;
    logic                    cmd_ready_q;
    logic                    cmd_fire;
    logic                    aw_fire;
    logic                    beat_fire;
    logic                    last_beat;

    assign cmd_fire  = cmd_valid && cmd_ready_q;
    assign aw_fire   = (state == AW) && m_axi_awready;
    assign last_beat = (state == W_DATA) && (cnt == awlen_q);
    assign beat_fire = m_axi_wvalid && m_axi_wready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire)                 state_next = AW;
            AW:      if (aw_fire)                  state_next = W_DATA;
            W_DATA:  if (beat_fire && last_beat)   state_next = W_RESP;
            W_RESP:  if (m_axi_bvalid)             state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state       <= IDLE;
            cnt         <= '0;
            awlen_q     <= '0;
            awaddr_q    <= '0;
            incr_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state       <= state_next;
            // Registered ready: follows the state we are about to enter, so
            // a command held through W_RESP is taken on the first IDLE cycle.
            cmd_ready_q <= (state_next == IDLE);
            if (cmd_fire) begin
                awaddr_q <= cmd_addr & ~LSB_MASK;
                awlen_q  <= cmd_len;
                incr_q   <= cmd_incr;
            end
            if (beat_fire)
                cnt <= last_beat ? 8'd0 : cnt + 8'd1;
        end
    end

    // Response: a mismatched bid means the response is not ours; report it
    // as a slave error rather than trusting the bresp that came with it.
    assign done      = (state == W_RESP) && m_axi_bvalid;
    assign done_resp = !done                  ? RESP_OKAY :
                       (m_axi_bid != AXI_ID)  ? RESP_SLVERR : m_axi_bresp;

    assign cmd_ready     = cmd_ready_q;
    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(ADDR_LSB);
    assign m_axi_awburst = incr_q ? BURST_INCR : BURST_FIXED;
    assign m_axi_awvalid = (state == AW);

    // W is gated on W_DATA so no beat can precede the AW handshake.
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = wr_strb;
    assign m_axi_wvalid  = wr_valid && (state == W_DATA);
    assign m_axi_wlast   = last_beat;
    assign wr_ready      = m_axi_wready && (state == W_DATA);

    assign m_axi_bready  = (state == W_RESP);

endmodule
